uart_rx_word: RTL

- Serial UART receiver that feeds the processor's UART load port (UART_DATA / W_UART) from an off-chip 8N1 serial line.
- Deserializes bytes, packs BYTES_PER_WORD bytes LSB-first into one word, then issues a single-cycle write strobe to the processor's RAM UART register.
- Sits between the board RX pin and the MIPS pipeline top-level, in the same clock domain as the core.

---
 rtl/uart_rx_word.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver packing BYTES_PER_WORD bytes LSB-first into one word.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx_word #(
  parameter int BIT_WIDTH      = 32,
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = BIT_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [BIT_WIDTH-1:0] UART_DATA,
  output logic                 W_UART,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST = BCW'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RECOVER
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_baud;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic [BCW-1:0]       r_byte_cnt;
  logic [BIT_WIDTH-1:0] r_word;
  logic [BIT_WIDTH-1:0] w_word_ins;
  logic                 w_tick;
  logic                 w_ld_half;
  logic                 w_ld_full;
  logic                 w_go_data;
  logic                 w_shift;
  logic                 w_accept;
  logic                 w_ferr;
  logic                 w_drop;
`ifdef UART_RX_PARITY_EN
  logic                 w_perr;
  logic                 r_drop;
  assign w_drop = r_drop;
`else
  assign w_drop     = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_tick = (r_baud == '0);
  assign busy   = (r_state != S_IDLE) || (r_byte_cnt != '0);

  always_comb begin
    w_word_ins = r_word;
    w_word_ins[{r_byte_cnt, 3'b000} +: 8] = r_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_half   = 1'b0;
    w_ld_full   = 1'b0;
    w_go_data   = 1'b0;
    w_shift     = 1'b0;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: if (!r_rx_s) begin
        w_state_nxt = S_START;
        w_ld_half   = 1'b1;
      end
      S_START: if (w_tick) begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
          w_ld_full   = 1'b1;
          w_go_data   = 1'b1;
        end
      end
      S_DATA: if (w_tick) begin
        w_shift   = 1'b1;
        w_ld_full = 1'b1;
        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) begin
        w_ld_full   = 1'b1;
        w_state_nxt = S_STOP;
        w_perr      = ^{r_shift, r_rx_s};
      end
`endif
      S_STOP: if (w_tick) begin
        if (r_rx_s) begin
          w_accept    = !w_drop;
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr      = 1'b1;
          w_ld_full   = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // Line must stay high for a whole bit before re-arming.
        if (!r_rx_s)     w_ld_full   = 1'b1;
        else if (w_tick) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      UART_DATA  <= '0;
      W_UART     <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      r_drop     <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx_serial;
      r_rx_s    <= r_rx_meta;
      W_UART    <= 1'b0;
      frame_err <= 1'b0;
      if (w_ld_half)         r_baud <= HALF;
      else if (w_ld_full)    r_baud <= FULL;
      else if (r_baud != '0) r_baud <= r_baud - 1'b1;
      if (w_go_data) r_bit_cnt <= '0;
      if (w_shift) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_accept) begin
        if (r_byte_cnt == LAST) begin
          UART_DATA  <= w_word_ins;
          W_UART     <= 1'b1;
          r_byte_cnt <= '0;
          r_word     <= '0;
        end else begin
          r_word     <= w_word_ins;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
      if (w_ferr) begin
        frame_err  <= 1'b1;
        r_byte_cnt <= '0;
        r_word     <= '0;
      end
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      if (w_perr) begin
        parity_err <= 1'b1;
        r_byte_cnt <= '0;
        r_word     <= '0;
        r_drop     <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_drop <= 1'b0;
      end
`endif
    end
  end

endmodule
